// File: rtl/reg_file_8x32.sv
// 8-entry register file with R0 hardwired to zero, two combinational read ports,
// one write port and a wrapping commit counter. Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file_8x32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [2:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [2:0]        read_reg_1,
  input  logic [2:0]        read_reg_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic [7:0]        write_count
);

  logic [DATA_W-1:0] regs_q [1:7];
  logic [DATA_W-1:0] rf_view [8];
  logic [7:0]        wr_en;
  logic [7:0]        count_q;
  logic [7:0]        count_d;
  logic              commit;

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    wr_en = 8'h00;
    if (RegWrite) begin
      case (write_reg)
        3'd1:    wr_en = 8'b0000_0010;
        3'd2:    wr_en = 8'b0000_0100;
        3'd3:    wr_en = 8'b0000_1000;
        3'd4:    wr_en = 8'b0001_0000;
        3'd5:    wr_en = 8'b0010_0000;
        3'd6:    wr_en = 8'b0100_0000;
        3'd7:    wr_en = 8'b1000_0000;
        default: wr_en = 8'h00;
      endcase
    end
  end

  assign commit  = |wr_en[7:1];
  assign count_d = commit ? count_q + 8'd1 : count_q;

  // NOTE: this storage is reset explicitly, because reset must clear R1..R7 without a clock; plain RAM arrays normally stay unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < 8; i++) regs_q[i] <= '0;
      count_q <= 8'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 1; i < 8; i++) begin
        if (wr_en[i]) regs_q[i] <= write_data;
      end
      count_q <= count_d;
    end
  end

  // Index 0 of the read view is a constant zero, so R0 needs no storage.
  always_comb begin
    rf_view[0] = '0;
    for (int i = 1; i < 8; i++) rf_view[i] = regs_q[i];
  end

  always_comb begin
    read_data_1 = '0;
    read_data_2 = '0;
    if (reset_n) begin
      read_data_1 = rf_view[read_reg_1];
      read_data_2 = rf_view[read_reg_2];
`ifdef REG_FILE_BYPASS_EN
      if (RegWrite && (write_reg != 3'd0) && (read_reg_1 == write_reg)) read_data_1 = write_data;
      if (RegWrite && (write_reg != 3'd0) && (read_reg_2 == write_reg)) read_data_2 = write_data;
`endif
    end
  end

  assign write_count = count_q;

endmodule

// File: tb/tb_reg_file_8x32.sv
// Self-checking bench for reg_file_8x32: directed scenarios plus random traffic
// against an array-based reference model.
module tb_reg_file_8x32;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        RegWrite;
  logic [2:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  read_reg_1;
  logic [2:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [7:0]  write_count;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [8];
  int unsigned count_m = 0;
  logic [31:0] last_r7;

  reg_file_8x32 #(.DATA_W(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .RegWrite    (RegWrite),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg_1  (read_reg_1),
    .read_reg_2  (read_reg_2),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value from the rules: zero in reset or for index 0, forwarded
  // data when bypass is built in and a write targets the same index, else stored value.
  function automatic logic [31:0] exp_read(input logic [2:0] idx);
    if (!reset_n || idx == 3'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (RegWrite === 1'b1 && write_reg != 3'd0 && write_reg == idx) return write_data;
`endif
    return model[idx];
  endfunction

  // One clock cycle: drive, check reads pre-edge, clock, update model, check counter.
  task automatic do_cycle(input logic we, input logic [2:0] wr, input logic [31:0] wd,
                          input logic [2:0] r1, input logic [2:0] r2, input string tag);
    RegWrite   = we;
    write_reg  = wr;
    write_data = wd;
    read_reg_1 = r1;
    read_reg_2 = r2;
    #2;
    check({tag, "_rd1_pre"}, read_data_1, exp_read(r1));
    check({tag, "_rd2_pre"}, read_data_2, exp_read(r2));
    @(posedge clk);
    if (we === 1'b1 && wr != 3'd0 && reset_n) begin
      model[wr] = wd;
      count_m   = (count_m + 1) % 256;
    end
    #1;
    check({tag, "_count"}, {24'h0, write_count}, count_m);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    reset_n    = 1'b0;
    RegWrite   = 1'b0;
    write_reg  = 3'd0;
    write_data = 32'h0;
    read_reg_1 = 3'd1;
    read_reg_2 = 3'd7;
    #1;
    check("reset_rd1", read_data_1, 32'h0);
    check("reset_rd2", read_data_2, 32'h0);
    check("reset_count", {24'h0, write_count}, 32'h0);

    @(negedge clk);
    reset_n = 1'b1;

    // First edge after release must accept the write.
    do_cycle(1'b1, 3'd3, 32'h0000_1234, 3'd3, 3'd0, "wr_r3");
    do_cycle(1'b0, 3'd0, 32'h0, 3'd3, 3'd3, "rd_r3");
    check("r3_value", read_data_1, 32'h0000_1234);
    check("r3_count", {24'h0, write_count}, 32'd1);

    do_cycle(1'b1, 3'd0, 32'hFFFF_FFFF, 3'd0, 3'd0, "wr_r0");
    do_cycle(1'b0, 3'd0, 32'h0, 3'd0, 3'd3, "rd_r0");
    check("r0_zero", read_data_1, 32'h0);
    check("r0_count", {24'h0, write_count}, 32'd1);

    do_cycle(1'b1, 3'd5, 32'hA5A5_A5A5, 3'd0, 3'd5, "wr_r5a");
    RegWrite = 1'b1; write_reg = 3'd5; write_data = 32'h5A5A_5A5A; read_reg_2 = 3'd5;
    #2;
`ifdef REG_FILE_BYPASS_EN
    check("r5_pre_edge", read_data_2, 32'h5A5A_5A5A);
`else
    check("r5_pre_edge", read_data_2, 32'hA5A5_A5A5);
`endif
    @(posedge clk);
    model[5] = 32'h5A5A_5A5A;
    count_m  = (count_m + 1) % 256;
    #1;
    RegWrite = 1'b0;
    #1;
    check("r5_post_edge", read_data_2, 32'h5A5A_5A5A);

    for (int n = 0; n < 200; n++) begin
      logic [2:0] wr;
      logic [2:0] r1;
      logic [2:0] r2;
      wr = 3'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 3'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 3) == 0) ? wr : 3'($urandom_range(0, 7));
      do_cycle(1'($urandom_range(0, 1)), wr, $urandom, r1, r2, "rand");
    end

    // Reads of R2 with an unknown write index and no write enable.
    do_cycle(1'b0, 3'bxxx, 32'hDEAD_BEEF, 3'd2, 3'd2, "x_wr_idx");
    check("x_ports_match", read_data_1, read_data_2);
    check("x_r2_kept", read_data_1, model[2]);

    for (int i = 1; i < 8; i++) do_cycle(1'b1, 3'(i), 32'h1111_0000 + 32'(i), 3'(i), 3'd0, "fill");
    do_cycle(1'b0, 3'd0, 32'h0, 3'd7, 3'd1, "fill_rd");
    check("fill_r7", read_data_1, 32'h1111_0007);

    // Reset pulse between edges with a write pending: must clear at once and block the write.
    RegWrite = 1'b1; write_reg = 3'd4; write_data = 32'hCAFE_F00D;
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      read_reg_1 = 3'(i);
      read_reg_2 = 3'(7 - i);
      #1;
      check("rst_mid_rd1", read_data_1, 32'h0);
      check("rst_mid_rd2", read_data_2, 32'h0);
      check("rst_mid_count", {24'h0, write_count}, 32'h0);
    end
    @(posedge clk);
    #1;
    read_reg_1 = 3'd4;
    #1;
    check("rst_write_blocked", read_data_1, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    RegWrite = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    count_m = 0;
    do_cycle(1'b0, 3'd0, 32'h0, 3'd4, 3'd6, "post_rst");

    for (int n = 0; n < 256; n++) begin
      last_r7 = $urandom;
      do_cycle(1'b1, 3'd7, last_r7, 3'd7, 3'd1, "wrap");
    end
    check("wrap_count", {24'h0, write_count}, 32'h0);
    read_reg_1 = 3'd7;
    RegWrite = 1'b0;
    #1;
    check("wrap_r7", read_data_1, last_r7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
